bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit decade counter.
- Adds DIGITS-wide cascaded BCD counting, up/down direction, synchronous parallel load with BCD validity check, and wrap or saturate mode.
- Provides a terminal-count output for cascading further counter instances, plus a registered wrap pulse for event counting and timebase generation.

Parameters:
- DIGITS, 2, number of BCD digits (>=1); count range 0 .. 10^DIGITS-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk edge).
- enable  input  1  count enable; 1 = advance one step per clock.
- up_dn  input  1  direction; 1 = count up, 0 = count down.
- sat_mode  input  1  0 = wrap at terminal count, 1 = saturate (hold) at terminal count.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  BCD load value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- cnt  output  4*DIGITS  registered BCD count, same digit packing as load_val.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse on wrap-around.
- load_err  output  1  registered one-cycle pulse on rejected load.

Behaviour:
- Reset (reset=0 at clk edge): cnt=0, wrap=0, load_err=0. Reset overrides load and enable. Reset mid-count clears the count immediately on that edge.
- Priority per edge: reset > load > enable > hold.
- Load, valid (load=1 and every digit of load_val <= 9):
  - cnt <= load_val on that edge, regardless of enable; no count step that cycle.
  - wrap=0, load_err=0 for that cycle.
- Load, invalid (load=1 and any digit >= 0xA):
  - cnt holds its value (no count step, even if enable=1).
  - load_err=1 for exactly the next cycle.
- Count up (enable=1, load=0, up_dn=1):
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - A digit advances only when every lower digit is 9.
- Count down (enable=1, load=0, up_dn=0):
  - Digit 0 decrements.
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - A digit advances only when every lower digit is 0.
- Terminal states: all digits 9 when counting up; all digits 0 when counting down.
- At a terminal state with enable=1, load=0:
  - sat_mode=0: cnt wraps (up: all-9 -> all-0; down: all-0 -> all-9); wrap=1 for exactly the next cycle.
  - sat_mode=1: cnt holds; wrap stays 0.
- wrap=0 and load_err=0 in every cycle not described above; neither output ever stays high two consecutive cycles for a single event.
- tc = enable & ~load & (cnt at terminal for the current up_dn).
  - Purely combinational from registered cnt and the inputs; zero latency.
  - Used as the next instance's enable.
- Direction change mid-count: takes effect on the next edge; no glitch or skipped value.
- enable=0 and load=0: cnt holds; tc=0.
- cnt never leaves valid BCD (each digit 0..9) under any input sequence.
- Latency: one clock from enable/load to cnt update.

Test Plan (DIGITS=2):
1. Reset: reset=0 for 2 cycles with enable=1, load=1, load_val=8'h42 -> cnt=8'h00, wrap=0, load_err=0, tc=0.
2. Up count with wrap:
   - reset=1, enable=1, up_dn=1, sat_mode=0 from 8'h00; after 10 edges -> cnt=8'h10.
   - After 99 edges -> cnt=8'h99 and tc=1.
   - Next edge -> cnt=8'h00, wrap=1 for exactly 1 cycle.
3. Down count:
   - sat_mode=0 from 8'h00, up_dn=0 -> tc=1; next edge cnt=8'h99, wrap pulse.
   - Then load 8'h10 and count down -> sequence 8'h10, 8'h09, 8'h08.
   - sat_mode=1 at 8'h00 -> cnt holds 8'h00 for 5 edges, wrap=0.
4. Load:
   - load=1, load_val=8'h57, enable=1 -> cnt=8'h57 next cycle (not 8'h58), load_err=0.
   - load_val=8'h5A -> cnt unchanged, load_err=1 for one cycle.
5. Saturate up: sat_mode=1, load 8'h98, enable=1, up_dn=1 -> 8'h99, then holds 8'h99; tc=1 throughout at 99; wrap=0.
6. Hold, direction change and reset mid-count:
   - At 8'h35, enable=0 for 3 cycles -> holds 8'h35, tc=0.
   - up_dn flip then enable=1 -> 8'h34.
   - reset=0 with enable=1 -> 8'h00 on that edge.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit cascaded BCD up/down counter with parallel load, wrap/saturate
// modes, combinational terminal count and registered wrap/load-error pulses.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  sat_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    logic [4*DIGITS-1:0] step_val;
    logic                at_term;
    logic                load_ok;

    // Ripple carry/borrow across digits; a digit moves only while every lower
    // digit sits at its rollover value. The final carry marks the terminal state.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        step_val = cnt_q;
        carry    = 1'b1;
        digit    = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            digit = cnt_q[4*k +: 4];
            if (carry) begin
                if (up_dn) begin
                    step_val[4*k +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                    carry              = (digit == 4'd9);
                end else begin
                    step_val[4*k +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                    carry              = (digit == 4'd0);
                end
            end
        end
        at_term = carry;
    end

    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                cnt_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable) begin
            if (at_term && sat_mode) begin
                cnt_d = cnt_q;
            end else begin
                // Stepping from the terminal state rolls every digit over,
                // which is exactly the wrap-around value.
                cnt_d  = step_val;
                wrap_d = at_term;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their next-state values from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt      = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = enable & ~load & at_term;

endmodule
